// File: rtl/led_counter_pkg.sv
// Shared constants and helpers for the LED counter: mode encodings and a
// constant-foldable ceil(log2) used to size the prescale counter.
package led_counter_pkg;

  localparam logic [1:0] MODE_UP     = 2'd0;
  localparam logic [1:0] MODE_DOWN   = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_HOLD   = 2'd3;

  // Returns ceil(log2(value)); 0 for value <= 1.
  function automatic int clog2(input int value);
    int v;
    int r;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/led_counter_if.sv
// Control and status bundle of the LED counter. The master drives the
// controls and observes the registered counter outputs; the counter is the slave.
interface led_counter_if #(
  parameter int WIDTH = 8
);
  import led_counter_pkg::*;

  logic             en;
  logic [1:0]       mode;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] leds;
  logic             tc;
  logic             dir;

  modport master (
    output en, mode, clear, load, load_val,
    input  leds, tc, dir
  );

  modport slave (
    input  en, mode, clear, load, load_val,
    output leds, tc, dir
  );

endinterface

// File: rtl/led_prescaler.sv
// Divides count steps down to one every PRESCALE running cycles. The phase
// freezes while run is low and is forced back to zero by restart.
module led_prescaler
  import led_counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic restart,
  output logic tick
);

  localparam int CW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = run && (cnt_q == LAST);

endmodule

// File: rtl/led_counter_param.sv
// Parametrised LED bank counter: up, down, bounce or hold, with prescaled
// stepping, synchronous clear/load, a wrap limit and a terminal-count pulse.
module led_counter_param
  import led_counter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_COUNT = 2**WIDTH - 1,
  parameter int PRESCALE  = 1
) (
  input  logic          clk,
  input  logic          rst,
  led_counter_if.slave  bus
);

  if (WIDTH < 2 || MAX_COUNT < 1 || MAX_COUNT > (2**WIDTH) - 1 || PRESCALE < 1) begin : g_param_check
    $error("led_counter_param: illegal WIDTH/MAX_COUNT/PRESCALE combination");
  end

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

  logic [WIDTH-1:0] leds_q, leds_d;
  logic             dir_q, dir_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] eff;
  logic             run;
  logic             step;

  assign run = bus.en && (bus.mode != MODE_HOLD);

  led_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .restart (bus.clear | bus.load),
    .tick    (step)
  );

  // An out-of-range count is treated as sitting on the limit.
  assign eff = (leds_q > MAX_V) ? MAX_V : leds_q;

  always_comb begin
    leds_d = leds_q;
    dir_d  = dir_q;
    tc_d   = 1'b0;
    if (bus.clear) begin
      leds_d = '0;
      dir_d  = 1'b1;
    end else if (bus.load) begin
      leds_d = (bus.load_val > MAX_V) ? MAX_V : bus.load_val;
    end else if (step) begin
      case (bus.mode)
        MODE_UP: begin
          if (eff == MAX_V) begin
            leds_d = '0;
            tc_d   = 1'b1;
          end else begin
            leds_d = eff + ONE_V;
          end
        end
        MODE_DOWN: begin
          if (eff == '0) begin
            leds_d = MAX_V;
            tc_d   = 1'b1;
          end else begin
            leds_d = eff - ONE_V;
          end
        end
        MODE_BOUNCE: begin
          if (dir_q) begin
            if (eff == MAX_V) begin
              dir_d  = 1'b0;
              leds_d = MAX_V - ONE_V;
              tc_d   = 1'b1;
            end else begin
              leds_d = eff + ONE_V;
            end
          end else begin
            if (eff == '0) begin
              dir_d  = 1'b1;
              leds_d = ONE_V;
              tc_d   = 1'b1;
            end else begin
              leds_d = eff - ONE_V;
            end
          end
        end
        default: begin
          leds_d = leds_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      leds_q <= '0;
      dir_q  <= 1'b1;
      tc_q   <= 1'b0;
    end else begin
      leds_q <= leds_d;
      dir_q  <= dir_d;
      tc_q   <= tc_d;
    end
  end

  assign bus.leds = leds_q;
  assign bus.tc   = tc_q;
  assign bus.dir  = dir_q;

endmodule

// File: tb/tb_led_counter_param.sv
// Bench for led_counter_param: three instances cover plain wrap, bounce with a
// small limit, and prescaled stepping; expected outputs flow through a queue.
module tb_led_counter_param;
  import led_counter_pkg::*;

  localparam int W = 4;

  typedef struct {
    logic         en;
    logic [1:0]   mode;
    logic         clear;
    logic         load;
    logic [W-1:0] lv;
    logic [W-1:0] leds;
    logic         tc;
    logic         dir;
  } vec_t;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W+1:0] exp_q[$];
  vec_t tbl[$];

  led_counter_if #(.WIDTH(W)) if_a ();
  led_counter_if #(.WIDTH(W)) if_b ();
  led_counter_if #(.WIDTH(W)) if_c ();

  led_counter_param #(.WIDTH(W), .MAX_COUNT(9), .PRESCALE(1)) dut_a (
    .clk (clk), .rst (rst), .bus (if_a)
  );
  led_counter_param #(.WIDTH(W), .MAX_COUNT(3), .PRESCALE(1)) dut_b (
    .clk (clk), .rst (rst), .bus (if_b)
  );
  led_counter_param #(.WIDTH(W), .MAX_COUNT(9), .PRESCALE(4)) dut_c (
    .clk (clk), .rst (rst), .bus (if_c)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks
  task automatic drive(input int d, input logic en, input logic [1:0] mode,
                       input logic clear, input logic load, input logic [W-1:0] lv);
    case (d)
      0: begin if_a.en = en; if_a.mode = mode; if_a.clear = clear; if_a.load = load; if_a.load_val = lv; end
      1: begin if_b.en = en; if_b.mode = mode; if_b.clear = clear; if_b.load = load; if_b.load_val = lv; end
      default: begin if_c.en = en; if_c.mode = mode; if_c.clear = clear; if_c.load = load; if_c.load_val = lv; end
    endcase
  endtask

  function automatic logic [W+1:0] sample(input int d);
    case (d)
      0:       return {if_a.tc, if_a.dir, if_a.leds};
      1:       return {if_b.tc, if_b.dir, if_b.leds};
      default: return {if_c.tc, if_c.dir, if_c.leds};
    endcase
  endfunction

  // Scoreboard
  task automatic check(input string name, input logic [W+1:0] act);
    logic [W+1:0] exp;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: no expected entry queued, got tc=%0b dir=%0b leds=%0d",
               name, act[W+1], act[W], act[W-1:0]);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        n_fail++;
        $display("FAIL %s @%0t: got tc=%0b dir=%0b leds=%0d, expected tc=%0b dir=%0b leds=%0d",
                 name, $time, act[W+1], act[W], act[W-1:0], exp[W+1], exp[W], exp[W-1:0]);
      end
    end
  endtask

  task automatic step(input int d, input string name, input logic en, input logic [1:0] mode,
                      input logic clear, input logic load, input logic [W-1:0] lv,
                      input logic [W-1:0] leds, input logic tc, input logic dir);
    drive(d, en, mode, clear, load, lv);
    exp_q.push_back({tc, dir, leds});
    @(posedge clk);
    #1;
    check(name, sample(d));
  endtask

  function automatic vec_t v(input logic en, input logic [1:0] mode, input logic clear,
                             input logic load, input int lv, input int leds,
                             input logic tc, input logic dir);
    vec_t r;
    r.en = en; r.mode = mode; r.clear = clear; r.load = load;
    r.lv = W'(lv); r.leds = W'(leds); r.tc = tc; r.dir = dir;
    return r;
  endfunction

  task automatic run_table(input int d, input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      step(d, $sformatf("%s[%0d]", name, i), tbl[i].en, tbl[i].mode, tbl[i].clear,
           tbl[i].load, tbl[i].lv, tbl[i].leds, tbl[i].tc, tbl[i].dir);
    end
    tbl.delete();
  endtask

  task automatic random_run(input int n);
    logic [W-1:0] m;
    logic         tc;
    logic         en;
    logic [1:0]   mode;
    logic         clr;
    logic         ld;
    logic [W-1:0] lv;
    int           sel;
    step(0, "rand_clear", 1'b0, MODE_UP, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
    m = 4'd0;
    for (int i = 0; i < n; i++) begin
      en   = 1'($urandom_range(0, 1));
      sel  = $urandom_range(0, 2);
      mode = (sel == 0) ? MODE_UP : (sel == 1) ? MODE_DOWN : MODE_HOLD;
      clr  = ($urandom_range(0, 15) == 0);
      ld   = ($urandom_range(0, 7) == 0);
      lv   = W'($urandom_range(0, 15));
      tc   = 1'b0;
      if (clr) begin
        m = 4'd0;
      end else if (ld) begin
        m = (lv > 4'd9) ? 4'd9 : lv;
      end else if (en && mode == MODE_UP) begin
        if (m == 4'd9) begin m = 4'd0; tc = 1'b1; end else m = m + 4'd1;
      end else if (en && mode == MODE_DOWN) begin
        if (m == 4'd0) begin m = 4'd9; tc = 1'b1; end else m = m - 4'd1;
      end
      step(0, "random", en, mode, clr, ld, lv, m, tc, 1'b1);
    end
  endtask

  initial begin
    drive(0, 1'b1, MODE_UP, 1'b0, 1'b0, 4'd0);
    drive(1, 1'b0, MODE_HOLD, 1'b0, 1'b0, 4'd0);
    drive(2, 1'b0, MODE_HOLD, 1'b0, 1'b0, 4'd0);

    rst = 1'b1;
    step(0, "reset_0", 1'b1, MODE_UP, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
    step(0, "reset_1", 1'b1, MODE_UP, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
    exp_q.push_back({1'b0, 1'b1, 4'd0});
    check("reset_b", sample(1));
    exp_q.push_back({1'b0, 1'b1, 4'd0});
    check("reset_c", sample(2));
    rst = 1'b0;
    step(0, "reset_release", 1'b1, MODE_UP, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 1'b1);

    // UP wrap at 9 with an enable gap and a HOLD
    tbl.push_back(v(1, MODE_UP, 0, 0, 0, 2, 0, 1));
    tbl.push_back(v(1, MODE_UP, 0, 0, 0, 3, 0, 1));
    tbl.push_back(v(1, MODE_UP, 0, 0, 0, 4, 0, 1));
    tbl.push_back(v(1, MODE_UP, 0, 0, 0, 5, 0, 1));
    tbl.push_back(v(0, MODE_UP, 0, 0, 0, 5, 0, 1));
    tbl.push_back(v(0, MODE_UP, 0, 0, 0, 5, 0, 1));
    tbl.push_back(v(0, MODE_UP, 0, 0, 0, 5, 0, 1));
    tbl.push_back(v(1, MODE_UP, 0, 0, 0, 6, 0, 1));
    tbl.push_back(v(1, MODE_UP, 0, 0, 0, 7, 0, 1));
    tbl.push_back(v(1, MODE_UP, 0, 0, 0, 8, 0, 1));
    tbl.push_back(v(1, MODE_UP, 0, 0, 0, 9, 0, 1));
    tbl.push_back(v(1, MODE_UP, 0, 0, 0, 0, 1, 1));
    tbl.push_back(v(1, MODE_UP, 0, 0, 0, 1, 0, 1));
    tbl.push_back(v(1, MODE_HOLD, 0, 0, 0, 1, 0, 1));
    tbl.push_back(v(1, MODE_HOLD, 0, 0, 0, 1, 0, 1));
    run_table(0, "up_wrap");

    // DOWN wrap and load clamping
    tbl.push_back(v(1, MODE_DOWN, 0, 1, 2, 2, 0, 1));
    tbl.push_back(v(1, MODE_DOWN, 0, 0, 0, 1, 0, 1));
    tbl.push_back(v(1, MODE_DOWN, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(1, MODE_DOWN, 0, 0, 0, 9, 1, 1));
    tbl.push_back(v(1, MODE_DOWN, 0, 0, 0, 8, 0, 1));
    tbl.push_back(v(1, MODE_DOWN, 0, 1, 15, 9, 0, 1));
    tbl.push_back(v(1, MODE_DOWN, 0, 0, 0, 8, 0, 1));
    run_table(0, "down_wrap");

    // Priority: clear over load, load over a due step (and its wrap)
    tbl.push_back(v(1, MODE_UP, 1, 1, 5, 0, 0, 1));
    tbl.push_back(v(1, MODE_UP, 0, 1, 5, 5, 0, 1));
    tbl.push_back(v(1, MODE_UP, 0, 1, 9, 9, 0, 1));
    tbl.push_back(v(1, MODE_UP, 0, 1, 3, 3, 0, 1));
    tbl.push_back(v(1, MODE_UP, 0, 0, 0, 4, 0, 1));
    run_table(0, "priority");

    random_run(40);
    drive(0, 1'b0, MODE_HOLD, 1'b0, 1'b0, 4'd0);

    // BOUNCE with MAX_COUNT=3, HOLD resume, clamped load onto the limit
    tbl.push_back(v(0, MODE_BOUNCE, 1, 0, 0, 0, 0, 1));
    tbl.push_back(v(1, MODE_BOUNCE, 0, 0, 0, 1, 0, 1));
    tbl.push_back(v(1, MODE_BOUNCE, 0, 0, 0, 2, 0, 1));
    tbl.push_back(v(1, MODE_BOUNCE, 0, 0, 0, 3, 0, 1));
    tbl.push_back(v(1, MODE_BOUNCE, 0, 0, 0, 2, 1, 0));
    tbl.push_back(v(1, MODE_BOUNCE, 0, 0, 0, 1, 0, 0));
    tbl.push_back(v(1, MODE_BOUNCE, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, MODE_BOUNCE, 0, 0, 0, 1, 1, 1));
    tbl.push_back(v(1, MODE_BOUNCE, 0, 0, 0, 2, 0, 1));
    tbl.push_back(v(1, MODE_BOUNCE, 0, 0, 0, 3, 0, 1));
    tbl.push_back(v(1, MODE_BOUNCE, 0, 0, 0, 2, 1, 0));
    tbl.push_back(v(1, MODE_HOLD, 0, 0, 0, 2, 0, 0));
    tbl.push_back(v(1, MODE_HOLD, 0, 0, 0, 2, 0, 0));
    tbl.push_back(v(1, MODE_BOUNCE, 0, 0, 0, 1, 0, 0));
    tbl.push_back(v(1, MODE_BOUNCE, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, MODE_BOUNCE, 0, 0, 0, 1, 1, 1));
    tbl.push_back(v(1, MODE_BOUNCE, 0, 1, 7, 3, 0, 1));
    tbl.push_back(v(1, MODE_BOUNCE, 0, 0, 0, 2, 1, 0));
    run_table(1, "bounce");

    // Reset in the middle of a downward bounce
    rst = 1'b1;
    step(1, "rst_mid_bounce", 1'b1, MODE_BOUNCE, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
    rst = 1'b0;
    step(1, "after_rst_bounce", 1'b1, MODE_BOUNCE, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 1'b1);
    drive(1, 1'b0, MODE_HOLD, 1'b0, 1'b0, 4'd0);

    // PRESCALE=4: spacing, load restart, HOLD phase freeze, tc with prescale
    tbl.push_back(v(0, MODE_UP, 1, 0, 0, 0, 0, 1));
    tbl.push_back(v(1, MODE_UP, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(1, MODE_UP, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(1, MODE_UP, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(1, MODE_UP, 0, 0, 0, 1, 0, 1));
    tbl.push_back(v(1, MODE_UP, 0, 0, 0, 1, 0, 1));
    tbl.push_back(v(1, MODE_UP, 0, 0, 0, 1, 0, 1));
    tbl.push_back(v(1, MODE_UP, 0, 0, 0, 1, 0, 1));
    tbl.push_back(v(1, MODE_UP, 0, 0, 0, 2, 0, 1));
    tbl.push_back(v(1, MODE_UP, 0, 0, 0, 2, 0, 1));
    tbl.push_back(v(1, MODE_UP, 0, 0, 0, 2, 0, 1));
    tbl.push_back(v(1, MODE_UP, 0, 1, 5, 5, 0, 1));
    tbl.push_back(v(1, MODE_UP, 0, 0, 0, 5, 0, 1));
    tbl.push_back(v(1, MODE_UP, 0, 0, 0, 5, 0, 1));
    tbl.push_back(v(1, MODE_UP, 0, 0, 0, 5, 0, 1));
    tbl.push_back(v(1, MODE_UP, 0, 0, 0, 6, 0, 1));
    tbl.push_back(v(1, MODE_UP, 0, 0, 0, 6, 0, 1));
    tbl.push_back(v(1, MODE_UP, 0, 0, 0, 6, 0, 1));
    tbl.push_back(v(1, MODE_HOLD, 0, 0, 0, 6, 0, 1));
    tbl.push_back(v(1, MODE_HOLD, 0, 0, 0, 6, 0, 1));
    tbl.push_back(v(1, MODE_HOLD, 0, 0, 0, 6, 0, 1));
    tbl.push_back(v(1, MODE_UP, 0, 0, 0, 6, 0, 1));
    tbl.push_back(v(1, MODE_UP, 0, 0, 0, 7, 0, 1));
    tbl.push_back(v(0, MODE_UP, 0, 1, 9, 9, 0, 1));
    tbl.push_back(v(1, MODE_UP, 0, 0, 0, 9, 0, 1));
    tbl.push_back(v(1, MODE_UP, 0, 0, 0, 9, 0, 1));
    tbl.push_back(v(1, MODE_UP, 0, 0, 0, 9, 0, 1));
    tbl.push_back(v(1, MODE_UP, 0, 0, 0, 0, 1, 1));
    tbl.push_back(v(1, MODE_UP, 0, 0, 0, 0, 0, 1));
    run_table(2, "prescale");

    // Final report
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
